multicycle_control_fsm: RTL and testbench

// Main control state machine for the multicycle datapath. Decodes the 6-bit IR opcode
// and sequences fetch/decode/execute/memory/writeback, driving every datapath select and

---
 rtl/multicycle_control_fsm_if.sv | 33 +++
 rtl/multicycle_control_fsm.sv | 142 ++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: decode inputs and datapath control bundle for the multicycle control FSM
interface multicycle_control_fsm_if #(
    parameter int OP_SIZE   = 6,
    parameter int CNT_WIDTH = 32
);
    logic [OP_SIZE-1:0]   opcode;
    logic                 mem_ready;
    logic                 pcWrite;
    logic                 pcWriteCond;
    logic                 memGetData;
    logic                 memRead;
    logic                 memWrite;
    logic                 irWrite;
    logic                 regWrite;
    logic [1:0]           regWriteDataSel;
    logic                 aluSrcA;
    logic [1:0]           aluSrcB;
    logic [3:0]           aluOP;
    logic [1:0]           pcSrc;
    logic                 halted;
    logic                 illegal;
    logic [CNT_WIDTH-1:0] retired;
    modport master (
        input  opcode, mem_ready,
        output pcWrite, pcWriteCond, memGetData, memRead, memWrite, irWrite, regWrite,
               regWriteDataSel, aluSrcA, aluSrcB, aluOP, pcSrc, halted, illegal, retired
    );
    modport slave (
        output opcode, mem_ready,
        input  pcWrite, pcWriteCond, memGetData, memRead, memWrite, irWrite, regWrite,
               regWriteDataSel, aluSrcA, aluSrcB, aluOP, pcSrc, halted, illegal, retired
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: fetch/decode/execute/memory/writeback sequencer driving every datapath select and strobe
module multicycle_control_fsm #(
    parameter int         OP_SIZE   = 6,
    parameter int         CNT_WIDTH = 32,
    parameter logic [3:0] ALU_ADD   = 4'h0,
    parameter logic [3:0] ALU_SUB   = 4'h1
) (
    input logic clk,
    input logic rst_n,
    multicycle_control_fsm_if.master bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE,
        EXECUTE, ALU_WB, BRANCH, JUMP, LI_WB, HALT
    } stateT;

    localparam logic [OP_SIZE-1:0] OP_ADDI  = OP_SIZE'(6'h10);
    localparam logic [OP_SIZE-1:0] OP_LOAD  = OP_SIZE'(6'h20);
    localparam logic [OP_SIZE-1:0] OP_STORE = OP_SIZE'(6'h21);
    localparam logic [OP_SIZE-1:0] OP_BEQ   = OP_SIZE'(6'h30);
    localparam logic [OP_SIZE-1:0] OP_JUMP  = OP_SIZE'(6'h38);
    localparam logic [OP_SIZE-1:0] OP_LI    = OP_SIZE'(6'h3C);
    localparam logic [OP_SIZE-1:0] OP_HALT  = OP_SIZE'(6'h3F);

    stateT                state, next;
    logic [OP_SIZE-1:0]   opReg;
    logic                 badOp;
    logic                 illegalReg;
    logic [CNT_WIDTH-1:0] retiredCnt;
    logic                 decR, latR;

    assign decR        = bus.opcode[OP_SIZE-1:4] == '0;
    assign latR        = opReg[OP_SIZE-1:4] == '0;
    assign bus.illegal = illegalReg;
    assign bus.retired = retiredCnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FETCH;
            opReg      <= '0;
            illegalReg <= 1'b0;
            retiredCnt <= '0;
        end else begin
            state <= next;
            if (state == DECODE) opReg <= bus.opcode;
            if (badOp) illegalReg <= 1'b1;
            if (state != FETCH && next == FETCH) retiredCnt <= retiredCnt + CNT_WIDTH'(1);
        end
    end

    // Everything is forced low while rst_n is held so an in-flight RAM access drops at once.
    always_comb begin
        next                = state;
        badOp               = 1'b0;
        bus.pcWrite         = 1'b0;
        bus.pcWriteCond     = 1'b0;
        bus.memGetData      = 1'b0;
        bus.memRead         = 1'b0;
        bus.memWrite        = 1'b0;
        bus.irWrite         = 1'b0;
        bus.regWrite        = 1'b0;
        bus.regWriteDataSel = 2'b00;
        bus.aluSrcA         = 1'b0;
        bus.aluSrcB         = 2'b00;
        bus.aluOP           = 4'h0;
        bus.pcSrc           = 2'b00;
        bus.halted          = 1'b0;
        if (rst_n) begin
            case (state)
                FETCH: begin
                    bus.memRead = 1'b1;
                    bus.aluSrcB = 2'b01;
                    bus.aluOP   = ALU_ADD;
                    bus.irWrite = bus.mem_ready;
                    bus.pcWrite = bus.mem_ready;
                    next        = bus.mem_ready ? DECODE : FETCH;
                end
                DECODE: begin
                    bus.aluSrcB = 2'b11;
                    bus.aluOP   = ALU_ADD;
                    next        = (decR || bus.opcode == OP_ADDI) ? EXECUTE :
                                  (bus.opcode == OP_LOAD || bus.opcode == OP_STORE) ? MEM_ADDR :
                                  bus.opcode == OP_BEQ ? BRANCH :
                                  bus.opcode == OP_JUMP ? JUMP :
                                  bus.opcode == OP_LI ? LI_WB : HALT;
                    badOp       = next == HALT && bus.opcode != OP_HALT;
                end
                MEM_ADDR: begin
                    bus.aluSrcA = 1'b1;
                    bus.aluSrcB = 2'b10;
                    bus.aluOP   = ALU_ADD;
                    next        = opReg == OP_LOAD ? MEM_READ : MEM_WRITE;
                end
                MEM_READ: begin
                    bus.memGetData = 1'b1;
                    bus.memRead    = 1'b1;
                    next           = bus.mem_ready ? MEM_WB : MEM_READ;
                end
                MEM_WB: begin
                    bus.regWrite        = 1'b1;
                    bus.regWriteDataSel = 2'b01;
                    next                = FETCH;
                end
                MEM_WRITE: begin
                    bus.memGetData = 1'b1;
                    bus.memWrite   = 1'b1;
                    next           = bus.mem_ready ? FETCH : MEM_WRITE;
                end
                EXECUTE: begin
                    bus.aluSrcA = 1'b1;
                    bus.aluSrcB = latR ? 2'b00 : 2'b10;
                    bus.aluOP   = latR ? opReg[3:0] : ALU_ADD;
                    next        = ALU_WB;
                end
                ALU_WB: begin
                    bus.regWrite = 1'b1;
                    bus.aluOP    = latR ? opReg[3:0] : ALU_ADD;
                    next         = FETCH;
                end
                BRANCH: begin
                    bus.aluSrcA     = 1'b1;
                    bus.aluOP       = ALU_SUB;
                    bus.pcWriteCond = 1'b1;
                    bus.pcSrc       = 2'b01;
                    next            = FETCH;
                end
                JUMP: begin
                    bus.pcWrite = 1'b1;
                    bus.pcSrc   = 2'b10;
                    next        = FETCH;
                end
                LI_WB: begin
                    bus.regWrite        = 1'b1;
                    bus.regWriteDataSel = 2'b10;
                    next                = FETCH;
                end
                HALT:    bus.halted = 1'b1;
                default: next = FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: randomized instruction streams checked against a per-instruction phase model
module tb_multicycle_control_fsm;
    localparam logic [3:0] ADD = 4'h0;
    localparam logic [3:0] SUB = 4'h1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int retiredModel = 0;
    logic [18:0] expQ[$];
    logic [18:0] obsQ[$];
    bit rdyQ[$];
    logic [31:0] retObs;

    multicycle_control_fsm_if bus ();
    multicycle_control_fsm dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    function automatic logic [18:0] cw(input logic pw, pwc, mgd, mr, mw, iw, rw,
                                       input logic [1:0] sel, input logic sa,
                                       input logic [1:0] sb, input logic [3:0] op,
                                       input logic [1:0] ps, input logic h);
        return {pw, pwc, mgd, mr, mw, iw, rw, sel, sa, sb, op, ps, h};
    endfunction

    function automatic logic [18:0] obs();
        return {bus.pcWrite, bus.pcWriteCond, bus.memGetData, bus.memRead, bus.memWrite,
                bus.irWrite, bus.regWrite, bus.regWriteDataSel, bus.aluSrcA, bus.aluSrcB,
                bus.aluOP, bus.pcSrc, bus.halted};
    endfunction

    function automatic void add(input logic [18:0] w, input bit r);
        expQ.push_back(w);
        rdyQ.push_back(r);
    endfunction

    // Builds the expected per-cycle control words of one instruction from its class, then plays it.
    task automatic runInstr(input logic [5:0] op, input int fw, input int mw);
        int dec;
        bit retires;
        logic [3:0] aop;
        expQ = {};
        rdyQ = {};
        obsQ = {};
        retires = 1;
        for (int i = 0; i < fw; i++) add(cw(0,0,0,1,0,0,0,2'd0,0,2'd1,ADD,2'd0,0), 0);
        add(cw(1,0,0,1,0,1,0,2'd0,0,2'd1,ADD,2'd0,0), 1);
        dec = expQ.size();
        add(cw(0,0,0,0,0,0,0,2'd0,0,2'd3,ADD,2'd0,0), 1'($urandom));
        if (op < 6'h10 || op == 6'h10) begin
            aop = (op < 6'h10) ? op[3:0] : ADD;
            add(cw(0,0,0,0,0,0,0,2'd0,1,(op < 6'h10) ? 2'd0 : 2'd2,aop,2'd0,0), 1'($urandom));
            add(cw(0,0,0,0,0,0,1,2'd0,0,2'd0,aop,2'd0,0), 1'($urandom));
        end else if (op == 6'h20 || op == 6'h21) begin
            add(cw(0,0,0,0,0,0,0,2'd0,1,2'd2,ADD,2'd0,0), 1'($urandom));
            for (int i = 0; i <= mw; i++)
                add(cw(0,0,1,op == 6'h20,op == 6'h21,0,0,2'd0,0,2'd0,4'h0,2'd0,0), i == mw);
            if (op == 6'h20) add(cw(0,0,0,0,0,0,1,2'd1,0,2'd0,4'h0,2'd0,0), 1'($urandom));
        end else if (op == 6'h30) add(cw(0,1,0,0,0,0,0,2'd0,1,2'd0,SUB,2'd1,0), 1'($urandom));
        else if (op == 6'h38) add(cw(1,0,0,0,0,0,0,2'd0,0,2'd0,4'h0,2'd2,0), 1'($urandom));
        else if (op == 6'h3C) add(cw(0,0,0,0,0,0,1,2'd2,0,2'd0,4'h0,2'd0,0), 1'($urandom));
        else begin
            retires = 0;
            for (int i = 0; i < 10; i++) add(cw(0,0,0,0,0,0,0,2'd0,0,2'd0,4'h0,2'd0,1), 1'($urandom));
        end
        foreach (expQ[i]) begin
            bus.mem_ready = rdyQ[i];
            bus.opcode = (i == dec) ? op : 6'($urandom);
            @(negedge clk);
            obsQ.push_back(obs());
            if (i == 0) retObs = bus.retired;
            @(posedge clk);
            #1;
        end
        if (retires) retiredModel++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        bus.opcode = 6'h00;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== 19'd0) begin errors++; $display("FAIL reset_outputs cyc%0d got=%h exp=0", i, obs()); end
            @(posedge clk);
        end
        #1 rst_n = 1'b1;
        retiredModel = 0;
        checks++;
        if (bus.retired !== 32'd0) begin errors++; $display("FAIL reset_retired got=%0d exp=0", bus.retired); end
        checks++;
        if (bus.illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", bus.illegal); end
        @(negedge clk);
        checks++;
        if (obs() !== cw(1,0,0,1,0,1,0,2'd0,0,2'd1,ADD,2'd0,0))
            begin errors++; $display("FAIL first_fetch got=%h exp=%h", obs(), cw(1,0,0,1,0,1,0,2'd0,0,2'd1,ADD,2'd0,0)); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 19'd0) begin errors++; $display("FAIL reset_drops_memRead got=%h exp=0", obs()); end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_add();
        runInstr(6'h00, 0, 0);
        checks++;
        if (obsQ.size() != 4) begin errors++; $display("FAIL add_len got=%0d exp=4", obsQ.size()); end
        foreach (expQ[i]) begin
            checks++;
            if (obsQ[i] !== expQ[i]) begin errors++; $display("FAIL add cyc%0d got=%h exp=%h", i, obsQ[i], expQ[i]); end
        end
        checks++;
        if (bus.retired !== 32'(retiredModel)) begin errors++; $display("FAIL add_retired got=%0d exp=%0d", bus.retired, retiredModel); end
    endtask

    task automatic test_load();
        runInstr(6'h20, 0, 3);
        foreach (expQ[i]) begin
            checks++;
            if (obsQ[i] !== expQ[i]) begin errors++; $display("FAIL load cyc%0d got=%h exp=%h", i, obsQ[i], expQ[i]); end
        end
        checks++;
        if (bus.retired !== 32'(retiredModel)) begin errors++; $display("FAIL load_retired got=%0d exp=%0d", bus.retired, retiredModel); end
    endtask

    task automatic test_classes();
        logic [5:0] ops[4] = '{6'h21, 6'h30, 6'h38, 6'h3C};
        foreach (ops[k]) begin
            runInstr(ops[k], k % 2, 2);
            checks++;
            if (retObs !== 32'(retiredModel - 1)) begin errors++; $display("FAIL class_retired op=%h got=%0d exp=%0d", ops[k], retObs, retiredModel - 1); end
            foreach (expQ[i]) begin
                checks++;
                if (obsQ[i] !== expQ[i]) begin errors++; $display("FAIL class op=%h cyc%0d got=%h exp=%h", ops[k], i, obsQ[i], expQ[i]); end
            end
        end
        checks++;
        if (bus.retired !== 32'(retiredModel)) begin errors++; $display("FAIL classes_retired got=%0d exp=%0d", bus.retired, retiredModel); end
    endtask

    task automatic test_random();
        logic [5:0] legal[7] = '{6'h00, 6'h10, 6'h20, 6'h21, 6'h30, 6'h38, 6'h3C};
        logic [5:0] op;
        for (int n = 0; n < 40; n++) begin
            op = legal[$urandom_range(6, 0)];
            if (op == 6'h00) op = 6'($urandom_range(15, 0));
            runInstr(op, $urandom_range(2, 0), $urandom_range(3, 0));
            checks++;
            if (retObs !== 32'(retiredModel - 1)) begin errors++; $display("FAIL rand_retired n=%0d got=%0d exp=%0d", n, retObs, retiredModel - 1); end
            foreach (expQ[i]) begin
                checks++;
                if (obsQ[i] !== expQ[i]) begin errors++; $display("FAIL rand n=%0d op=%h cyc%0d got=%h exp=%h", n, op, i, obsQ[i], expQ[i]); end
            end
        end
        checks++;
        if (bus.retired !== 32'(retiredModel)) begin errors++; $display("FAIL rand_final_retired got=%0d exp=%0d", bus.retired, retiredModel); end
    endtask

    task automatic test_halt();
        logic [5:0] ops[2] = '{6'h3F, 6'h25};
        foreach (ops[k]) begin
            runInstr(ops[k], 1, 0);
            foreach (expQ[i]) begin
                checks++;
                if (obsQ[i] !== expQ[i]) begin errors++; $display("FAIL halt op=%h cyc%0d got=%h exp=%h", ops[k], i, obsQ[i], expQ[i]); end
            end
            checks++;
            if (bus.illegal !== (ops[k] != 6'h3F)) begin errors++; $display("FAIL halt_illegal op=%h got=%b exp=%b", ops[k], bus.illegal, ops[k] != 6'h3F); end
            checks++;
            if (bus.retired !== 32'(retiredModel)) begin errors++; $display("FAIL halt_retired op=%h got=%0d exp=%0d", ops[k], bus.retired, retiredModel); end
            rst_n = 1'b0;
            @(posedge clk);
            #1 rst_n = 1'b1;
            retiredModel = 0;
            checks++;
            if (bus.illegal !== 1'b0 || bus.halted !== 1'b0 || bus.retired !== 32'd0)
                begin errors++; $display("FAIL halt_reset_clear illegal=%b halted=%b retired=%0d exp=0/0/0", bus.illegal, bus.halted, bus.retired); end
        end
    endtask

    task automatic test_store_reset();
        bus.mem_ready = 1'b1;
        bus.opcode = 6'h21;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        bus.opcode = 6'h00;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (obs() !== cw(0,0,1,0,1,0,0,2'd0,0,2'd0,4'h0,2'd0,0)) begin errors++; $display("FAIL store_wait got=%h exp=%h", obs(), cw(0,0,1,0,1,0,0,2'd0,0,2'd0,4'h0,2'd0,0)); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 19'd0) begin errors++; $display("FAIL store_reset_drop got=%h exp=0", obs()); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        retiredModel = 0;
        @(negedge clk);
        checks++;
        if (obs() !== cw(0,0,0,1,0,0,0,2'd0,0,2'd1,ADD,2'd0,0)) begin errors++; $display("FAIL store_resume_fetch got=%h exp=%h", obs(), cw(0,0,0,1,0,0,0,2'd0,0,2'd1,ADD,2'd0,0)); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.mem_ready = 1'b1;
        bus.opcode = 6'h00;
        test_reset();
        test_add();
        test_load();
        test_classes();
        test_random();
        test_halt();
        test_store_reset();
        test_add();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
